// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid & ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = StEmpty;
        main_d  = RESET_VALUE;
        skid_d  = RESET_VALUE;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (in_fire) begin
              state_d = StBusy;
              main_d  = in_data;
            end
          end
          StBusy: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              state_d = StFull;
              skid_d  = in_data;
            end else if (out_fire) begin
              // main keeps the departed word; out_valid drops instead
              state_d = StEmpty;
            end
          end
          StFull: begin
            if (out_fire) begin
              state_d = StBusy;
              main_d  = skid_q;
            end
          end
          default: state_d = StEmpty;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= StEmpty;
        main_q  <= RESET_VALUE;
        skid_q  <= RESET_VALUE;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != StFull);
      end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign occupancy = (state_q == StFull) ? 2'd2 : (state_q == StBusy) ? 2'd1 : 2'd0;

  end else begin : g_noskid
    logic [WIDTH-1:0] main_q;
    logic             valid_q;
    logic             in_fire, out_fire;

    assign in_ready = ~valid_q | out_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = valid_q & out_ready;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        main_q  <= RESET_VALUE;
        valid_q <= 1'b0;
      end else if (flush) begin
        main_q  <= RESET_VALUE;
        valid_q <= 1'b0;
      end else if (in_fire) begin
        main_q  <= in_data;
        valid_q <= 1'b1;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end

    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign occupancy = {1'b0, valid_q};
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus a random soak of a SKID=1
// and a SKID=0 instance against queue-based reference models.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV1 = 32'h0000_0013;
  localparam logic [31:0] RV0 = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        flush1 = 0, in_valid1 = 0, out_ready1 = 0;
  logic [31:0] in_data1 = '0;
  logic        in_ready1, out_valid1;
  logic [31:0] out_data1;
  logic [1:0]  occ1;

  logic        flush0 = 0, in_valid0 = 0, out_ready0 = 0;
  logic [31:0] in_data0 = '0;
  logic        in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [1:0]  occ0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV1), .SKID(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(32), .RESET_VALUE(RV0), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occ0)
  );

  // Reference models: a FIFO of held words plus the last word left in the register.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] last1, last0;
  bit          started1;

  function automatic bit exp_ready1();
    return started1 && (q1.size() < 2);
  endfunction
  function automatic bit exp_ready0();
    return (q0.size() == 0) || out_ready0;
  endfunction
  function automatic logic [31:0] exp_data1();
    return (q1.size() != 0) ? q1[0] : last1;
  endfunction
  function automatic logic [31:0] exp_data0();
    return (q0.size() != 0) ? q0[0] : last0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1.delete(); q0.delete();
      last1 = RV1; last0 = RV0;
      started1 = 0;
    end else begin
      bit fi1, fo1, fi0, fo0;
      fi1 = in_valid1 && exp_ready1();
      fo1 = (q1.size() != 0) && out_ready1;
      fi0 = in_valid0 && exp_ready0();
      fo0 = (q0.size() != 0) && out_ready0;
      started1 = 1;
      if (flush1) begin
        q1.delete(); last1 = RV1;
      end else begin
        if (fo1) last1 = q1.pop_front();
        if (fi1) q1.push_back(in_data1);
      end
      if (flush0) begin
        q0.delete(); last0 = RV0;
      end else begin
        if (fo0) last0 = q0.pop_front();
        if (fi0) q0.push_back(in_data0);
      end
    end
  end

  task automatic test_reset();
    in_valid1 = 1; in_data1 = 32'hDEAD_0001; out_ready1 = 0;
    @(negedge clk);
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid1); else n_pass++;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL rst_occ got %0d want 0", occ1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready1); else n_pass++;
    n_checks++; if (out_data1 !== RV1) $display("FAIL rst_out_data got %h want %h", out_data1, RV1); else n_pass++;
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL rst0_out_valid got %b want 0", out_valid0); else n_pass++;
    rst = 1;
    @(negedge clk);
    n_checks++; if (in_ready1 !== 1'b1) $display("FAIL rel_in_ready got %b want 1", in_ready1); else n_pass++;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL rel_occ got %0d want 0", occ1); else n_pass++;
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd1) $display("FAIL first_acc_occ got %0d want 1", occ1); else n_pass++;
    n_checks++; if (out_data1 !== 32'hDEAD_0001) $display("FAIL first_acc_data got %h want dead0001", out_data1); else n_pass++;
    in_valid1 = 0; out_ready1 = 1;
    @(negedge clk);
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL drain_out_valid got %b want 0", out_valid1); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    out_ready1 = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid1 = 1; in_data1 = words[i];
      @(negedge clk);
      n_checks++; if (out_data1 !== words[i]) $display("FAIL stream_data[%0d] got %h want %h", i, out_data1, words[i]); else n_pass++;
      n_checks++; if (occ1 !== 2'd1) $display("FAIL stream_occ[%0d] got %0d want 1", i, occ1); else n_pass++;
      n_checks++; if (in_ready1 !== 1'b1) $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready1); else n_pass++;
    end
    in_valid1 = 0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready1 = 0; in_valid1 = 1; in_data1 = 32'hA;
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd1) $display("FAIL bp_occ1 got %0d want 1", occ1); else n_pass++;
    in_data1 = 32'hB;
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd2) $display("FAIL bp_occ2 got %0d want 2", occ1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b0) $display("FAIL bp_ready got %b want 0", in_ready1); else n_pass++;
    n_checks++; if (out_data1 !== 32'hA) $display("FAIL bp_hold got %h want a", out_data1); else n_pass++;
    in_valid1 = 0;
    @(negedge clk);
    n_checks++; if (out_data1 !== 32'hA) $display("FAIL bp_hold2 got %h want a", out_data1); else n_pass++;
    out_ready1 = 1;
    @(negedge clk);
    n_checks++; if (out_data1 !== 32'hB) $display("FAIL bp_drain_b got %h want b", out_data1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b1) $display("FAIL bp_ready_back got %b want 1", in_ready1); else n_pass++;
    n_checks++; if (occ1 !== 2'd1) $display("FAIL bp_occ_after got %0d want 1", occ1); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid1); else n_pass++;
  endtask

  task automatic test_flush_full();
    out_ready1 = 0; in_valid1 = 1; in_data1 = 32'hC;
    @(negedge clk);
    in_data1 = 32'hD;
    @(negedge clk);
    n_checks++; if (occ1 !== 2'd2) $display("FAIL fl_pre_occ got %0d want 2", occ1); else n_pass++;
    flush1 = 1; in_data1 = 32'hEE; out_ready1 = 1;
    @(negedge clk);
    flush1 = 0; in_valid1 = 0;
    n_checks++; if (occ1 !== 2'd0) $display("FAIL fl_occ got %0d want 0", occ1); else n_pass++;
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL fl_valid got %b want 0", out_valid1); else n_pass++;
    n_checks++; if (out_data1 !== RV1) $display("FAIL fl_data got %h want %h", out_data1, RV1); else n_pass++;
    n_checks++; if (in_ready1 !== 1'b1) $display("FAIL fl_ready got %b want 1", in_ready1); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid1 !== 1'b0) $display("FAIL fl_no_capture got %b want 0", out_valid1); else n_pass++;
  endtask

  task automatic test_noskid();
    out_ready0 = 0; in_valid0 = 1; in_data0 = 32'h5;
    @(negedge clk);
    n_checks++; if (out_data0 !== 32'h5) $display("FAIL ns_data5 got %h want 5", out_data0); else n_pass++;
    in_data0 = 32'h6;
    #1;
    n_checks++; if (in_ready0 !== 1'b0) $display("FAIL ns_ready_blocked got %b want 0", in_ready0); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_data0 !== 32'h5) $display("FAIL ns_hold got %h want 5", out_data0); else n_pass++;
    out_ready0 = 1; in_data0 = 32'h7;
    #1;
    n_checks++; if (in_ready0 !== 1'b1) $display("FAIL ns_ready_comb got %b want 1", in_ready0); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b1) $display("FAIL ns_valid got %b want 1", out_valid0); else n_pass++;
    n_checks++; if (out_data0 !== 32'h7) $display("FAIL ns_replace got %h want 7", out_data0); else n_pass++;
    in_valid0 = 0;
    @(negedge clk);
    n_checks++; if (out_valid0 !== 1'b0) $display("FAIL ns_drain got %b want 0", out_valid0); else n_pass++;
  endtask

  task automatic test_soak(input int unsigned cycles);
    bit          stall1 = 0, stall0 = 0;
    logic [31:0] held1 = '0, held0 = '0;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_checks++; if (out_valid1 !== (q1.size() != 0)) $display("FAIL soak1_valid c=%0d got %b want %b", c, out_valid1, q1.size() != 0); else n_pass++;
      n_checks++; if (occ1 !== 2'(q1.size()) || occ1 > 2'd2) $display("FAIL soak1_occ c=%0d got %0d want %0d", c, occ1, q1.size()); else n_pass++;
      n_checks++; if (in_ready1 !== exp_ready1()) $display("FAIL soak1_ready c=%0d got %b want %b", c, in_ready1, exp_ready1()); else n_pass++;
      n_checks++; if (out_data1 !== exp_data1()) $display("FAIL soak1_data c=%0d got %h want %h", c, out_data1, exp_data1()); else n_pass++;
      if (stall1) begin
        n_checks++; if (out_data1 !== held1) $display("FAIL soak1_stable c=%0d got %h want %h", c, out_data1, held1); else n_pass++;
      end
      n_checks++; if (out_valid0 !== (q0.size() != 0)) $display("FAIL soak0_valid c=%0d got %b want %b", c, out_valid0, q0.size() != 0); else n_pass++;
      n_checks++; if (occ0 !== 2'(q0.size())) $display("FAIL soak0_occ c=%0d got %0d want %0d", c, occ0, q0.size()); else n_pass++;
      n_checks++; if (out_data0 !== exp_data0()) $display("FAIL soak0_data c=%0d got %h want %h", c, out_data0, exp_data0()); else n_pass++;
      if (stall0) begin
        n_checks++; if (out_data0 !== held0) $display("FAIL soak0_stable c=%0d got %h want %h", c, out_data0, held0); else n_pass++;
      end
      in_valid1  = ($urandom_range(0, 3) != 0);
      out_ready1 = ($urandom_range(0, 2) == 0);
      in_data1   = $urandom;
      flush1     = ($urandom_range(0, 47) == 0);
      in_valid0  = ($urandom_range(0, 1) != 0);
      out_ready0 = ($urandom_range(0, 2) != 0);
      in_data0   = $urandom;
      flush0     = ($urandom_range(0, 47) == 0);
      stall1 = out_valid1 && !out_ready1 && !flush1;
      held1  = out_data1;
      stall0 = out_valid0 && !out_ready0 && !flush0;
      held0  = out_data0;
      #1;
      n_checks++; if (in_ready0 !== exp_ready0()) $display("FAIL soak0_ready c=%0d got %b want %b", c, in_ready0, exp_ready0()); else n_pass++;
    end
    @(negedge clk);
    flush1 = 0; flush0 = 0; in_valid1 = 0; in_valid0 = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_noskid();
    test_soak(10000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
